// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency single-line memory responder with a read/write handshake.
// A request is latched in IDLE, counted down in BUSY, and completed with a one-cycle
// pmem_resp pulse in RESP. Dropping the request during BUSY abandons it.
module pmem_responder #(
  parameter int unsigned LATENCY    = 10,
  parameter int unsigned INDEX_BITS = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         conflict
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned LINES  = 1 << INDEX_BITS;
  localparam logic [15:0] IDX_MASK = 16'(((1 << INDEX_BITS) - 1) << 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;
  logic                    accept;
  logic                    enter_resp;
  logic                    req_held;
  logic [INDEX_BITS-1:0]   idx_q;
  logic                    op_write;
  logic [LINE_W-1:0]       wdata_q;
  logic [LINE_W-1:0]       mem [LINES];

  // Offset bits and address bits above the index alias onto the same line.
  logic unused_addr;
  assign unused_addr = ^(pmem_address & ~IDX_MASK);

  // The latched operation's own request line decides whether it is still wanted.
  assign req_held = op_write ? pmem_write : pmem_read;

  // State and countdown register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state logic; an abort in BUSY outranks reaching the end of the countdown.
  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          accept     = 1'b1;
          count_next = CNT_W'(LATENCY - 1);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (!req_held) begin
          count_next = '0;
          state_next = IDLE;
        end else if (count == '0) begin
          enter_resp = 1'b1;
          state_next = RESP;
        end else begin
          count_next = count - CNT_W'(1);
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Request capture, completion pulse, read data and sticky conflict flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      conflict   <= 1'b0;
      idx_q      <= '0;
      op_write   <= 1'b0;
      wdata_q    <= '0;
    end else begin
      pmem_resp <= enter_resp;
      if (accept) begin
        idx_q    <= pmem_address[INDEX_BITS+3:4];
        op_write <= pmem_write;
        wdata_q  <= pmem_wdata;
        if (pmem_read && pmem_write) begin
          conflict <= 1'b1;
        end
      end
      if (enter_resp && !op_write) begin
        pmem_rdata <= mem[idx_q];
      end
    end
  end

  // Line storage; deliberately not cleared by reset, and a reset edge never commits.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && op_write) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Testbench for pmem_responder: randomized and directed traffic against a line-level
// reference model, with responses checked by a scoreboard monitor.
module tb_pmem_responder;

  localparam int L0 = 10;
  localparam int L1 = 1;
  localparam int IB = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  addr;
  logic         rd, wr;
  logic [127:0] wdata, rdata;
  logic         resp, conflict;

  logic [15:0]  addr1;
  logic         rd1, wr1;
  logic [127:0] wdata1, rdata1;
  logic         resp1, conflict1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int           edge_no;
    logic [127:0] rdata;
  } exp_t;

  exp_t         sbq[$];
  logic [127:0] model_mem [int];
  logic [127:0] model_rdata;
  logic         model_conflict;
  int           pool[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pmem_responder #(.LATENCY(L0), .INDEX_BITS(IB)) dut (
    .clk(clk), .rst(rst), .pmem_address(addr), .pmem_read(rd), .pmem_write(wr),
    .pmem_wdata(wdata), .pmem_rdata(rdata), .pmem_resp(resp), .conflict(conflict)
  );

  pmem_responder #(.LATENCY(L1), .INDEX_BITS(IB)) dut1 (
    .clk(clk), .rst(rst), .pmem_address(addr1), .pmem_read(rd1), .pmem_write(wr1),
    .pmem_wdata(wdata1), .pmem_rdata(rdata1), .pmem_resp(resp1), .conflict(conflict1)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int line_of(input logic [15:0] a);
    return (int'(a) >> 4) % (1 << IB);
  endfunction

  // Scoreboard monitor: every completion pulse must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (resp) begin
      if (sbq.size() == 0) begin
        check("unexpected_resp", 128'(resp), 128'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("resp_edge", 128'(cyc), 128'(e.edge_no));
        check("rdata", rdata, e.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request while the model says the responder is idle.
  // drop_after < 0 holds the request to completion; otherwise it is dropped mid-flight.
  task automatic do_op(input bit is_wr, input bit is_rd, input logic [15:0] a,
                       input logic [127:0] d, input int drop_after);
    int  e0;
    bit  seen;
    addr  = a;
    wdata = d;
    wr    = is_wr;
    rd    = is_rd;
    e0    = cyc + 1;
    if (is_wr && is_rd) model_conflict = 1'b1;
    if (drop_after < 0) begin
      exp_t e;
      if (is_wr) model_mem[line_of(a)] = d;
      else       model_rdata = model_mem[line_of(a)];
      e.edge_no = e0 + L0;
      e.rdata   = model_rdata;
      sbq.push_back(e);
      tick();
      addr  = 16'($urandom);
      wdata = {$urandom, $urandom, $urandom, $urandom};
      seen  = 1'b0;
      for (int k = 0; k < L0 + 4 && !seen; k++) begin
        if (resp) seen = 1'b1;
        else      tick();
      end
      if (!seen) check("resp_timeout", 128'(0), 128'(1));
      wr = 1'b0;
      rd = 1'b0;
      tick();
    end else begin
      for (int k = 0; k < drop_after; k++) tick();
      addr  = 16'($urandom);
      wdata = {$urandom, $urandom, $urandom, $urandom};
      wr = 1'b0;
      rd = 1'b0;
      tick();
    end
    check("conflict", 128'(conflict), 128'(model_conflict));
  endtask

  // Reset arrives while a write is in flight; the write must not land.
  task automatic reset_during_write(input logic [15:0] a, input logic [127:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    rd    = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    wr  = 1'b0;
    tick();
    model_rdata    = '0;
    model_conflict = 1'b0;
    check("rst_busy_resp", 128'(resp), 128'(0));
    check("rst_busy_rdata", rdata, 128'(0));
    check("rst_busy_conflict", 128'(conflict), 128'(0));
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] line_a, line_b;
    rst = 1'b1;
    addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
    addr1 = '0; rd1 = 1'b0; wr1 = 1'b0; wdata1 = '0;
    model_rdata = '0;
    model_conflict = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("reset_resp", 128'(resp), 128'(0));
    check("reset_rdata", rdata, 128'(0));
    check("reset_conflict", 128'(conflict), 128'(0));
    check("reset_resp_l1", 128'(resp1), 128'(0));

    // Latency-1 instance: request held throughout, accepted on the first edge after reset.
    // Each line completes L1 edges after acceptance and the next is taken in the following idle cycle.
    rst = 1'b0;
    rd1 = 1'b1;
    begin
      int e0;
      e0 = cyc + 1;
      for (int k = 1; k <= 8; k++) begin
        tick();
        check("l1_resp_pattern", 128'(resp1), 128'(((cyc - e0) % (L1 + 2)) == L1));
      end
    end
    rd1 = 1'b0;
    tick();
    tick();

    // Write then read the same line through a different offset.
    line_a = 128'h0123456789ABCDEF0123456789ABCDEF;
    do_op(1'b1, 1'b0, 16'h1230, line_a, -1);
    do_op(1'b0, 1'b1, 16'h123A, '0, -1);
    pool.push_back(line_of(16'h1230));

    // An abandoned write leaves the line untouched.
    do_op(1'b1, 1'b0, 16'h0050, 128'hAAAA_5555_0000_FFFF_1234_5678_9ABC_DEF0, -1);
    do_op(1'b1, 1'b0, 16'h0050, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 3);
    do_op(1'b0, 1'b1, 16'h0050, '0, -1);
    pool.push_back(5);

    // Simultaneous read and write: write wins and the flag stays set.
    do_op(1'b1, 1'b1, 16'h0090, 128'h9999_0000_1111_2222_3333_4444_5555_6666, -1);
    do_op(1'b0, 1'b1, 16'h0095, '0, -1);
    pool.push_back(9);

    // Reset during a write: no commit, outputs cleared, conflict cleared.
    line_b = 128'hC0FFEE00_C0FFEE00_C0FFEE00_C0FFEE00;
    do_op(1'b1, 1'b0, 16'h0070, line_b, -1);
    reset_during_write(16'h0070, ~line_b);
    do_op(1'b0, 1'b1, 16'h0070, '0, -1);
    pool.push_back(7);

    // Offset bits are ignored.
    do_op(1'b1, 1'b0, 16'h0000, 128'h0F0F_F0F0_0F0F_F0F0_0F0F_F0F0_0F0F_F0F0, -1);
    do_op(1'b0, 1'b1, 16'h000F, '0, -1);
    pool.push_back(0);

    // Randomized traffic over previously written lines.
    for (int n = 0; n < 40; n++) begin
      int          sel, li, gap;
      logic [15:0] a;
      logic [127:0] d;
      sel = int'($urandom_range(0, 9));
      li  = pool[$urandom_range(0, pool.size() - 1)];
      a   = 16'((li << 4) | int'($urandom_range(0, 15)));
      d   = {$urandom, $urandom, $urandom, $urandom};
      if (sel < 5)       do_op(1'b1, 1'b0, a, d, -1);
      else if (sel < 9)  do_op(1'b0, 1'b1, a, '0, -1);
      else               do_op(1'b1, 1'b0, a, d, int'($urandom_range(1, L0 - 1)));
      gap = int'($urandom_range(0, 2));
      for (int k = 0; k < gap; k++) tick();
    end

    for (int k = 0; k < L0 + 4; k++) tick();
    check("pending_responses", 128'(sbq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
